// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared state encoding and truth-table constants for gate_truth_checker
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Truth tables indexed by {a,b}
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   localparam logic [1:0] LAST_VEC = 2'd3;

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter with a tick flag when the count reaches 1
module settle_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         tick
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec) begin
         value <= value - W'(1);
      end
   end

   assign tick = (value == W'(1));

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sweeps a 2-input gate through all vectors and checks y; GATE_TRUTH_FIRST_FAIL_EN adds first-failure capture
module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECTED      = TT_NAND
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt
`ifdef GATE_TRUTH_FIRST_FAIL_EN
   ,
   output logic       fail_valid,
   output logic [1:0] fail_vec,
   output logic       fail_y
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t     state;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic       tick;
   logic       running;
   logic       sample;
   logic       cnt_load;
   logic       cnt_dec;
   logic       mismatch;
   logic [2:0] err_next;

   assign running  = (state == RUN);
   assign sample   = running && tick;
   // Reload on sweep start and on every sample edge that advances to another vector
   assign cnt_load = (!running && start) || (sample && (idx != LAST_VEC));
   assign cnt_dec  = running && (cnt > 4'd1);
   assign mismatch = (y_in != EXPECTED[idx]);
   assign err_next = err_cnt + {2'b00, mismatch};

   assign a_out = idx[1];
   assign b_out = idx[0];

   settle_counter #(
      .W(4)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (SETTLE_LOAD),
      .dec      (cnt_dec),
      .value    (cnt),
      .tick     (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= 2'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= 3'd0;
`ifdef GATE_TRUTH_FIRST_FAIL_EN
         fail_valid <= 1'b0;
         fail_vec   <= 2'd0;
         fail_y     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= RUN;
                  idx     <= 2'd0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  err_cnt <= 3'd0;
`ifdef GATE_TRUTH_FIRST_FAIL_EN
                  fail_valid <= 1'b0;
                  fail_vec   <= 2'd0;
                  fail_y     <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (sample) begin
                  err_cnt <= err_next;
`ifdef GATE_TRUTH_FIRST_FAIL_EN
                  if (mismatch && !fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= idx;
                     fail_y     <= y_in;
                  end
`endif
                  if (idx != LAST_VEC) begin
                     idx <= idx + 2'd1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 3'd0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
